router_reg_p: RTL and testbench

ROUTER_REG_P -- requirements
Module: router_reg_p

---
 rtl/router_reg_p.sv | 155 +++++++++++++++
 tb/tb_router_reg_p.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_p.sv
// Router datapath register block: header capture, payload forwarding through a
// small hold buffer while the destination FIFO is full, and packet parity checking.
module router_reg_p #(
  parameter int DW         = 8,
  parameter int ADDR_W     = 2,
  parameter int HOLD_DEPTH = 2,
  parameter int PAR_MODE   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pkt_valid,
  input  logic [DW-1:0]                     din,
  input  logic                              fifo_full,
  input  logic                              detect_addr,
  input  logic                              lfd_state,
  input  logic                              ld_state,
  input  logic                              laf_state,
  input  logic                              full_state,
  input  logic                              rst_int_reg,
  output logic [DW-1:0]                     dout,
  output logic                              dout_vld,
  output logic                              parity_done,
  output logic                              low_pkt_valid,
  output logic                              err,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]   hold_cnt,
  output logic                              hold_ovf
);

  localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int CW = $clog2(HOLD_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(HOLD_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(HOLD_DEPTH - 1);

  logic [DW-1:0] header_reg;
  logic [DW-1:0] acc_reg;
  logic [DW-1:0] ext_parity_reg;
  logic          parity_done_d_reg;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] hold_cnt_next;
  logic [DW-1:0] hold_mem [HOLD_DEPTH];

  logic sel_det, sel_lfd, sel_ld, sel_laf;
  logic addr_ok, hold_empty, hold_full;
  logic push, pop, drop, chk_now;

  function automatic logic [DW-1:0] fold(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (PAR_MODE == 0) return a ^ b;
    else               return a + b;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_det    = detect_addr;
    sel_lfd    = ~detect_addr & lfd_state;
    sel_ld     = ~detect_addr & ~lfd_state & ld_state;
    sel_laf    = ~detect_addr & ~lfd_state & ~ld_state & laf_state;
    addr_ok    = (din[ADDR_W-1:0] != {ADDR_W{1'b1}});
    hold_empty = (hold_cnt == '0);
    hold_full  = (hold_cnt == DEPTH_C);
    // A word goes into the buffer when the FIFO is blocked, or when older words
    // are still waiting ahead of it; the oldest word leaves whenever the FIFO can take one.
    push       = sel_ld & (fifo_full ? ~hold_full : ~hold_empty);
    pop        = (sel_ld | sel_laf) & ~fifo_full & ~hold_empty;
    drop       = sel_ld & fifo_full & hold_full;
    chk_now    = parity_done & ~parity_done_d_reg;

    hold_cnt_next = hold_cnt;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    if (sel_det) begin
      hold_cnt_next = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (push && !pop)      hold_cnt_next = hold_cnt + 1'b1;
      else if (pop && !push) hold_cnt_next = hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) hold_mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout              <= '0;
      dout_vld          <= 1'b0;
      header_reg        <= '0;
      acc_reg           <= '0;
      ext_parity_reg    <= '0;
      parity_done       <= 1'b0;
      parity_done_d_reg <= 1'b0;
      low_pkt_valid     <= 1'b0;
      err               <= 1'b0;
      hold_ovf          <= 1'b0;
      hold_cnt          <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
    end else begin
      dout_vld          <= 1'b0;
      parity_done_d_reg <= parity_done;
      hold_cnt          <= hold_cnt_next;
      wr_ptr_reg        <= wr_ptr_next;
      rd_ptr_reg        <= rd_ptr_next;

      if (sel_det && pkt_valid && addr_ok) header_reg <= din;

      if (sel_det) begin
        acc_reg        <= '0;
        ext_parity_reg <= '0;
        parity_done    <= 1'b0;
        hold_ovf       <= 1'b0;
      end

      if (sel_lfd) begin
        dout     <= header_reg;
        dout_vld <= 1'b1;
        acc_reg  <= fold(acc_reg, header_reg);
      end

      if (sel_ld) begin
        if (!fifo_full) begin
          dout     <= hold_empty ? din : hold_mem[rd_ptr_reg];
          dout_vld <= 1'b1;
        end
        if (pkt_valid && !full_state) acc_reg <= fold(acc_reg, din);
        // The parity word is captured even if the FIFO is full; it never enters the accumulator.
        if (!pkt_valid && !parity_done) begin
          ext_parity_reg <= din;
          parity_done    <= 1'b1;
        end
      end

      if (sel_laf && !fifo_full && !hold_empty) begin
        dout     <= hold_mem[rd_ptr_reg];
        dout_vld <= 1'b1;
      end

      if (drop) hold_ovf <= 1'b1;

      if (rst_int_reg)                low_pkt_valid <= 1'b0;
      else if (sel_ld && !pkt_valid)  low_pkt_valid <= 1'b1;

      if (sel_det || rst_int_reg) err <= 1'b0;
      else if (chk_now)           err <= (acc_reg != ext_parity_reg);
    end
  end

endmodule

// File: tb/tb_router_reg_p.sv
// Scoreboard bench for router_reg_p: a queue-based packet model predicts the
// forwarded word order, hold-buffer state and parity result for both parity modes.
module tb_router_reg_p;

  localparam int HD = 2;

  logic       clk;
  logic       rst;
  logic       pkt_valid;
  logic [7:0] din;
  logic       fifo_full;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg;

  logic [7:0] dout, dout_b;
  logic       dout_vld, dout_vld_b;
  logic       parity_done, parity_done_b;
  logic       low_pkt_valid, low_pkt_valid_b;
  logic       err, err_b;
  logic [1:0] hold_cnt, hold_cnt_b;
  logic       hold_ovf, hold_ovf_b;

  router_reg_p #(.DW(8), .ADDR_W(2), .HOLD_DEPTH(HD), .PAR_MODE(0)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout), .dout_vld(dout_vld), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .hold_cnt(hold_cnt), .hold_ovf(hold_ovf)
  );

  router_reg_p #(.DW(8), .ADDR_W(2), .HOLD_DEPTH(HD), .PAR_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout_b), .dout_vld(dout_vld_b), .parity_done(parity_done_b),
    .low_pkt_valid(low_pkt_valid_b), .err(err_b), .hold_cnt(hold_cnt_b), .hold_ovf(hold_ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];   // expected dout sequence
  logic [7:0] mq[$];      // words the model believes are held
  logic       ovf_m;
  logic [7:0] hdr_m;
  logic [7:0] pay [0:15];
  logic       ffp [0:16];
  logic       fsp [0:15];
  logic [7:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 16; i++) begin
      pay[i] = '0;
      ffp[i] = 1'b0;
      fsp[i] = 1'b0;
    end
    ffp[16] = 1'b0;
  endtask

  task automatic strobes_off();
    detect_addr = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; fifo_full = 0; pkt_valid = 0;
  endtask

  // Model of one accepted word: forwarded at once, forwarded behind older words, held, or lost.
  task automatic accept(input logic [7:0] w, input logic f);
    if (!f) begin
      if (mq.size() == 0) exp_q.push_back(w);
      else begin
        exp_q.push_back(mq.pop_front());
        mq.push_back(w);
      end
    end else if (mq.size() < HD) mq.push_back(w);
    else ovf_m = 1'b1;
  endtask

  task automatic run_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par_in, input bit good);
    logic [7:0] a0, a1, par;
    int guard;
    strobes_off();
    detect_addr = 1; pkt_valid = 1; din = hdr;
    if (hdr[1:0] != 2'b11) hdr_m = hdr;
    mq.delete();
    ovf_m = 1'b0;
    step();
    chk("det_parity_done", parity_done, 0);
    chk("det_err", err, 0);
    chk("det_err_p1", err_b, 0);
    chk("det_hold_cnt", hold_cnt, 0);
    chk("det_hold_ovf", hold_ovf, 0);

    detect_addr = 0; lfd_state = 1; din = 8'($urandom);
    exp_q.push_back(hdr_m);
    a0 = hdr_m;
    a1 = hdr_m;
    step();

    lfd_state = 0; ld_state = 1;
    for (int i = 0; i < n; i++) begin
      din = pay[i]; fifo_full = ffp[i]; full_state = fsp[i];
      accept(pay[i], ffp[i]);
      if (!fsp[i]) begin
        a0 = a0 ^ pay[i];
        a1 = a1 + pay[i];
      end
      step();
    end
    par = good ? a0 : par_in;
    full_state = 0; pkt_valid = 0; din = par; fifo_full = ffp[n];
    accept(par, ffp[n]);
    step();
    chk("par_parity_done", parity_done, 1);
    chk("par_err_not_yet", err, 0);
    chk("par_low_pkt_valid", low_pkt_valid, 1);
    chk("par_hold_cnt", hold_cnt, mq.size());
    chk("par_hold_ovf", hold_ovf, ovf_m);

    ld_state = 0; laf_state = 1;
    guard = 0;
    do begin
      fifo_full = ($urandom_range(0, 3) == 0);
      if (!fifo_full && mq.size() != 0) exp_q.push_back(mq.pop_front());
      step();
      guard++;
    end while (mq.size() != 0 && guard < 64);
    if (mq.size() != 0) chk("laf_drain_bound", mq.size(), 0);
    laf_state = 0; fifo_full = 0;
    @(negedge clk);
    #1;
    chk("pkt_all_words_out", exp_q.size(), 0);
    chk("pkt_err", err, (a0 != par));
    chk("pkt_err_p1", err_b, (a1 != par));
    chk("pkt_hold_cnt_drained", hold_cnt, 0);
    step();
    chk("pkt_err_sticky", err, (a0 != par));
    $display("pkt hdr=%h n=%0d par=%h xor=%h sum=%h err=%b err_p1=%b ovf=%b",
             hdr, n, par, a0, a1, err, err_b, ovf_m);
  endtask

  always @(negedge clk) begin
    if (dout_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_unexpected: got %0h expected no output at %0t", dout, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", dout, mon_e);
        chk("dout_p1", dout_b, mon_e);
        chk("dout_vld_p1", dout_vld_b, 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d errors", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] h;
    int n;
    rst = 0;
    strobes_off();
    din = 0;
    hdr_m = 0;
    ovf_m = 0;
    clear_pat();
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_parity_done", parity_done, 0);
    chk("rst_low_pkt_valid", low_pkt_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_hold_cnt", hold_cnt, 0);
    chk("rst_hold_ovf", hold_ovf, 0);
    step();
    step();
    rst = 1;
    step();

    // Basic packet, good parity, then bad parity.
    clear_pat();
    pay[0] = 8'h11; pay[1] = 8'h22;
    run_pkt(8'h05, 2, 8'h36, 0);
    run_pkt(8'h05, 2, 8'h37, 0);
    for (int i = 0; i < 3; i++) step();
    chk("err_held_idle", err, 1);

    // Hold-buffer overflow with ordered drain.
    clear_pat();
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
    ffp[0] = 1; ffp[1] = 1; ffp[2] = 1; ffp[3] = 1;
    run_pkt(8'h06, 3, 8'h00, 1);

    // Invalid address: header register keeps 0x06.
    clear_pat();
    pay[0] = 8'h44;
    run_pkt(8'h03, 1, 8'h00, 1);

    // Checksum wrap: XOR instance flags, additive instance does not.
    clear_pat();
    pay[0] = 8'h90; pay[1] = 8'h7F;
    run_pkt(8'h80, 2, 8'h8F, 0);

    // rst_int_reg coinciding with a low pkt_valid load: clear wins.
    strobes_off();
    ld_state = 1; pkt_valid = 0; rst_int_reg = 1; din = 8'h5A;
    exp_q.push_back(8'h5A);
    step();
    chk("clr_low_pkt_valid", low_pkt_valid, 0);
    chk("clr_err", err, 0);
    chk("clr_parity_done_kept", parity_done, 1);
    strobes_off();
    @(negedge clk);
    #1;
    chk("clr_word_out", exp_q.size(), 0);
    $display("rst_int_reg clear done");

    for (int p = 0; p < 40; p++) begin
      clear_pat();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pay[i] = 8'($urandom);
        ffp[i] = ($urandom_range(0, 2) == 0);
        fsp[i] = ($urandom_range(0, 9) == 0);
      end
      ffp[n] = ($urandom_range(0, 2) == 0);
      h = 8'($urandom);
      if ($urandom_range(0, 7) == 0) h[1:0] = 2'b11;
      run_pkt(h, n, 8'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset mid-packet with one held word.
    strobes_off();
    detect_addr = 1; pkt_valid = 1; din = 8'h09;
    hdr_m = 8'h09;
    step();
    detect_addr = 0; lfd_state = 1;
    exp_q.push_back(8'h09);
    step();
    lfd_state = 0; ld_state = 1; din = 8'hC3; fifo_full = 1;
    step();
    chk("pre_rst_hold_cnt", hold_cnt, 1);
    strobes_off();
    rst = 0;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_dout_vld", dout_vld, 0);
    chk("arst_parity_done", parity_done, 0);
    chk("arst_low_pkt_valid", low_pkt_valid, 0);
    chk("arst_err", err, 0);
    chk("arst_hold_cnt", hold_cnt, 0);
    chk("arst_hold_ovf", hold_ovf, 0);
    chk("arst_hold_cnt_p1", hold_cnt_b, 0);
    exp_q.delete();
    mq.delete();
    hdr_m = 8'h00;
    step();
    step();
    rst = 1;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_idle_hold_cnt", hold_cnt, 0);
    $display("mid-packet reset done");

    clear_pat();
    pay[0] = 8'h3C; pay[1] = 8'hE7; ffp[0] = 1;
    run_pkt(8'h03, 2, 8'h00, 1);

    @(negedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
